// File: rtl/data_memory.sv
// Data-memory responder with a posted-store buffer: stores are queued in order,
// loads forward from the youngest matching queued store, and the queue drains on non-load cycles.
module data_memory #(
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              addr,
   input  logic [31:0]              write_data,
   input  logic                     mem_write,
   input  logic                     mem_read,
   output logic [31:0]              read_data,
   output logic                     stall,
   output logic [$clog2(DEPTH):0]   buf_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WORDS = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] idx;
   logic                  addr_unused;

   logic [ADDR_WIDTH-1:0] ent_idx_q  [DEPTH];
   logic [ADDR_WIDTH-1:0] ent_idx_d  [DEPTH];
   logic [31:0]           ent_data_q [DEPTH];
   logic [31:0]           ent_data_d [DEPTH];
   logic [DEPTH-1:0]      ent_vld_q;
   logic [DEPTH-1:0]      ent_vld_d;
   logic [PTR_W-1:0]      head_q;
   logic [PTR_W-1:0]      head_d;
   logic [PTR_W-1:0]      tail_q;
   logic [PTR_W-1:0]      tail_d;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;

   // Power-up contents are zero; reset deliberately leaves the array alone.
   logic [31:0]           ram_q [WORDS] = '{default: '0};
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [31:0]           ram_wdata;

   logic                  push;
   logic                  drain;
   logic                  fwd_hit;
   logic [31:0]           fwd_data;
   logic [PTR_W-1:0]      pos;

   assign idx         = addr[ADDR_WIDTH+1:2];
   assign addr_unused = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

   assign stall     = (count_q == CNT_W'(DEPTH));
   assign buf_count = count_q;
   assign push      = mem_write & ~stall;
   assign drain     = (count_q != '0) & ~mem_read;

   // Scan oldest to youngest so the last hit is the youngest matching store.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      pos      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pos = head_q + PTR_W'(k);
         if (ent_vld_q[pos] && (ent_idx_q[pos] == idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data_q[pos];
         end
      end
   end

   assign read_data = fwd_hit ? fwd_data : ram_q[idx];

   always_comb begin
      ent_idx_d  = ent_idx_q;
      ent_data_d = ent_data_q;
      ent_vld_d  = ent_vld_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      ram_we     = 1'b0;
      ram_waddr  = ent_idx_q[head_q];
      ram_wdata  = ent_data_q[head_q];

      if (drain) begin
         ram_we            = 1'b1;
         ent_vld_d[head_q] = 1'b0;
         head_d            = head_q + PTR_W'(1);
      end

      if (push) begin
         ent_idx_d[tail_q]  = idx;
         ent_data_d[tail_q] = write_data;
         ent_vld_d[tail_q]  = 1'b1;
         tail_d             = tail_q + PTR_W'(1);
      end

      case ({push, drain})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_idx_q  <= '{default: '0};
         ent_data_q <= '{default: '0};
         ent_vld_q  <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         ent_idx_q  <= ent_idx_d;
         ent_data_q <= ent_data_d;
         ent_vld_q  <= ent_vld_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_waddr] <= ram_wdata;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed vector table, hand sequences (wrap, async reset)
// and randomized traffic checked against a queue-based reference model.
module tb_data_memory;

   localparam int AW    = 10;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] read_data;
   logic        stall;
   logic [2:0]  buf_count;

   int errors = 0;
   int checks = 0;

   data_memory #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .write_data (write_data),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .read_data  (read_data),
      .stall      (stall),
      .buf_count  (buf_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Reference model: pending stores as a queue, RAM as a plain array.
   typedef struct {
      logic [AW-1:0] idx;
      logic [31:0]   data;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_ram [1 << AW];

   function automatic logic [31:0] model_rd(logic [31:0] a);
      logic [AW-1:0] ix;
      ix = a[AW+1:2];
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].idx == ix) return mq[i].data;
      return m_ram[ix];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      mem_write  = w;
      mem_read   = r;
      addr       = a;
      write_data = d;
      @(negedge clk);
      check("model_read_data", read_data, model_rd(a));
      check("model_stall", {31'b0, stall}, (mq.size() == DEPTH) ? 32'd1 : 32'd0);
      check("model_buf_count", 32'(buf_count), 32'(mq.size()));
   endtask

   task automatic tick();
      bit   push_ok;
      bit   drn;
      ent_t e;
      push_ok = mem_write && (mq.size() < DEPTH);
      drn     = (mq.size() > 0) && !mem_read;
      e.idx   = addr[AW+1:2];
      e.data  = write_data;
      @(posedge clk);
      if (drn) begin
         m_ram[mq[0].idx] = mq[0].data;
         mq.delete(0);
      end
      if (push_ok) mq.push_back(e);
      #1;
   endtask

   typedef struct {
      bit          w;
      bit          r;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      bit          st;
      int          cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit w, bit r, logic [31:0] a, logic [31:0] d,
                               logic [31:0] rd, bit st, int cnt);
      vec_t v;
      v.w = w; v.r = r; v.a = a; v.d = d; v.rd = rd; v.st = st; v.cnt = cnt;
      tbl.push_back(v);
   endfunction

   logic [31:0] old_vals [3];
   logic [31:0] a_tmp;

   initial begin
      foreach (m_ram[i]) m_ram[i] = '0;

      // store then load, then drain on idle
      add(1, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0);
      add(0, 1, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
      add(0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
      add(0, 1, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0);
      // youngest-match forwarding
      add(1, 1, 32'h20, 32'd1,        32'h0,        0, 0);
      add(1, 1, 32'h20, 32'd2,        32'd1,        0, 1);
      add(1, 1, 32'h24, 32'd3,        32'h0,        0, 2);
      add(0, 1, 32'h20, 32'h0,        32'd2,        0, 3);
      add(0, 0, 32'h20, 32'h0,        32'd2,        0, 3);
      add(0, 0, 32'h24, 32'h0,        32'd3,        0, 2);
      add(0, 0, 32'h20, 32'h0,        32'd2,        0, 1);
      add(0, 1, 32'h24, 32'h0,        32'd3,        0, 0);
      add(0, 1, 32'h20, 32'h0,        32'd2,        0, 0);
      // fill, stall, rejected store, drain frees slot, retry accepted
      add(1, 1, 32'h30, 32'hA0,       32'h0,        0, 0);
      add(1, 1, 32'h34, 32'hA1,       32'h0,        0, 1);
      add(1, 1, 32'h38, 32'hA2,       32'h0,        0, 2);
      add(1, 1, 32'h3C, 32'hA3,       32'h0,        0, 3);
      add(1, 1, 32'h40, 32'hA4,       32'h0,        1, 4);
      add(1, 0, 32'h40, 32'hA4,       32'h0,        1, 4);
      add(1, 1, 32'h40, 32'hA4,       32'h0,        0, 3);
      add(0, 1, 32'h40, 32'h0,        32'hA4,       1, 4);
      add(0, 1, 32'h30, 32'h0,        32'hA0,       1, 4);
      add(0, 1, 32'h34, 32'h0,        32'hA1,       1, 4);
      add(0, 0, 32'h3C, 32'h0,        32'hA3,       1, 4);
      add(0, 0, 32'h3C, 32'h0,        32'hA3,       0, 3);
      add(0, 0, 32'h3C, 32'h0,        32'hA3,       0, 2);
      add(0, 0, 32'h3C, 32'h0,        32'hA3,       0, 1);
      add(0, 1, 32'h3C, 32'h0,        32'hA3,       0, 0);
      add(0, 1, 32'h40, 32'h0,        32'hA4,       0, 0);
      // simultaneous push and drain
      add(1, 1, 32'h50, 32'hB0,       32'h0,        0, 0);
      add(1, 1, 32'h54, 32'hB1,       32'h0,        0, 1);
      add(1, 0, 32'h58, 32'hB2,       32'h0,        0, 2);
      add(0, 1, 32'h50, 32'h0,        32'hB0,       0, 2);
      add(0, 1, 32'h58, 32'h0,        32'hB2,       0, 2);
      add(0, 1, 32'h54, 32'h0,        32'hB1,       0, 2);

      reset = 1'b0; mem_write = 0; mem_read = 0; addr = '0; write_data = '0;
      #2;
      check("reset_buf_count", 32'(buf_count), 32'd0);
      check("reset_stall", {31'b0, stall}, 32'd0);
      #10 reset = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         apply(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
         check($sformatf("vec%0d_read_data", i), read_data, tbl[i].rd);
         check($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].st});
         check($sformatf("vec%0d_buf_count", i), 32'(buf_count), 32'(tbl[i].cnt));
         tick();
      end

      // drain leftovers
      for (int i = 0; i < 4; i++) begin apply(0, 0, 32'h0, 32'h0); tick(); end

      // pointer wrap: nine stores, each forwarded, steady push+drain
      for (int k = 0; k < 9; k++) begin
         apply(1, 0, 32'h200 + 32'(4 * k), 32'hC000_0000 + 32'(k));
         tick();
         apply(0, 1, 32'h200 + 32'(4 * k), 32'h0);
         check("wrap_forward", read_data, 32'hC000_0000 + 32'(k));
         tick();
      end
      apply(0, 0, 32'h0, 32'h0); tick();
      for (int k = 0; k < 9; k++) begin
         apply(0, 1, 32'h200 + 32'(4 * k), 32'h0);
         check("wrap_ram", read_data, 32'hC000_0000 + 32'(k));
         tick();
      end

      // randomized traffic; addresses carry junk in ignored bits
      for (int n = 0; n < 400; n++) begin
         a_tmp = {$urandom} & ~32'(((1 << AW) - 1) << 2);
         a_tmp = a_tmp | (32'($urandom_range(0, 7)) << 2);
         apply(bit'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
               a_tmp, $urandom);
         tick();
      end

      // async reset mid-operation
      for (int i = 0; i < 6; i++) begin apply(0, 0, 32'h0, 32'h0); tick(); end
      for (int k = 0; k < 3; k++) old_vals[k] = m_ram[16 + k];
      for (int k = 0; k < 3; k++) begin
         apply(1, 1, 32'h40 + 32'(4 * k), 32'h5000 + 32'(k));
         tick();
      end
      apply(0, 1, 32'h40, 32'h0);
      check("pre_reset_forward", read_data, 32'h5000);
      #2 reset = 1'b0;
      #1;
      check("async_reset_buf_count", 32'(buf_count), 32'd0);
      check("async_reset_stall", {31'b0, stall}, 32'd0);
      check("async_reset_read_old", read_data, old_vals[0]);
      mq.delete();
      #1 reset = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         apply(0, 0, 32'h40 + 32'(4 * k), 32'h0);
         check("post_reset_ram_kept", read_data, old_vals[k]);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
